// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: sync, blanking, visible coordinates,
// line/frame strobes and a frame counter, advanced by a pixel-clock-enable divider.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 1,
  parameter int COORD_W  = 10,
  parameter int FRAME_W  = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_enable,
  output logic               out_pix_valid,
  output logic               out_vga_hs,
  output logic               out_vga_vs,
  output logic               out_active,
  output logic               out_vblank,
  output logic [COORD_W-1:0] out_vga_x,
  output logic [COORD_W-1:0] out_vga_y,
  output logic               out_line_start,
  output logic               out_frame_start,
  output logic [FRAME_W-1:0] out_frame
);

  localparam int H_BLANK = H_FP + H_SYNC + H_BP;
  localparam int H_TOTAL = H_BLANK + H_ACTIVE;
  localparam int V_BLANK = V_FP + V_SYNC + V_BP;
  localparam int V_TOTAL = V_BLANK + V_ACTIVE;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [COORD_W-1:0] H_SYNC_BEG = COORD_W'(H_FP);
  localparam logic [COORD_W-1:0] H_SYNC_END = COORD_W'(H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] H_BLANK_C  = COORD_W'(H_BLANK);
  localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_SYNC_BEG = COORD_W'(V_FP);
  localparam logic [COORD_W-1:0] V_SYNC_END = COORD_W'(V_FP + V_SYNC);
  localparam logic [COORD_W-1:0] V_BLANK_C  = COORD_W'(V_BLANK);
  localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOTAL - 1);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);

  if ((H_TOTAL - 1) >= (1 << COORD_W) || (V_TOTAL - 1) >= (1 << COORD_W)) begin : g_coord_w_check
    $error("vga_timing_gen: COORD_W too narrow for H_TOTAL-1 / V_TOTAL-1");
  end
  if (CLK_DIV < 1) begin : g_clk_div_check
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  logic [DIV_W-1:0]   div;
  logic [COORD_W-1:0] xcount;
  logic [COORD_W-1:0] ycount;

  logic tick_p0, h_sync_p0, v_sync_p0, h_act_p0, v_act_p0, x_last_p0, y_last_p0;

  logic               vld_p1, hs_p1, vs_p1, active_p1, vblank_p1, ls_p1, fs_p1;
  logic [COORD_W-1:0] x_p1, y_p1;
  logic [FRAME_W-1:0] frame_p1;

  // Stage p0: decode the current raster position
  always_comb begin
    tick_p0   = in_enable && (div == DIV_LAST);
    h_sync_p0 = (xcount >= H_SYNC_BEG) && (xcount < H_SYNC_END);
    v_sync_p0 = (ycount >= V_SYNC_BEG) && (ycount < V_SYNC_END);
    h_act_p0  = (xcount >= H_BLANK_C);
    v_act_p0  = (ycount >= V_BLANK_C);
    x_last_p0 = (xcount == H_LAST);
    y_last_p0 = (ycount == V_LAST);
  end

  // Stage p1: register outputs on tick, then advance the raster counters
  always_ff @(posedge clock) begin
    if (reset) begin
      div       <= '0;
      xcount    <= '0;
      ycount    <= '0;
      vld_p1    <= 1'b0;
      ls_p1     <= 1'b0;
      fs_p1     <= 1'b0;
      hs_p1     <= ~HS_POL;
      vs_p1     <= ~VS_POL;
      active_p1 <= 1'b0;
      vblank_p1 <= 1'b1;
      x_p1      <= '0;
      y_p1      <= '0;
      frame_p1  <= '0;
    end else begin
      vld_p1 <= tick_p0;
      ls_p1  <= tick_p0 && (xcount == '0);
      fs_p1  <= tick_p0 && (xcount == '0) && (ycount == '0);
      // The divider phase is kept across in_enable=0 so resuming is seamless
      if (in_enable) div <= tick_p0 ? '0 : div + 1'b1;
      if (tick_p0) begin
        hs_p1     <= h_sync_p0 ? HS_POL : ~HS_POL;
        vs_p1     <= v_sync_p0 ? VS_POL : ~VS_POL;
        active_p1 <= h_act_p0 && v_act_p0;
        vblank_p1 <= !v_act_p0;
        x_p1      <= h_act_p0 ? xcount - H_BLANK_C : '0;
        y_p1      <= v_act_p0 ? ycount - V_BLANK_C : '0;
        if (x_last_p0) begin
          xcount <= '0;
          ycount <= y_last_p0 ? '0 : ycount + 1'b1;
          if (y_last_p0) frame_p1 <= frame_p1 + 1'b1;
        end else begin
          xcount <= xcount + 1'b1;
        end
      end
    end
  end

  assign out_pix_valid   = vld_p1;
  assign out_vga_hs      = hs_p1;
  assign out_vga_vs      = vs_p1;
  assign out_active      = active_p1;
  assign out_vblank      = vblank_p1;
  assign out_vga_x       = x_p1;
  assign out_vga_y       = y_p1;
  assign out_line_start  = ls_p1;
  assign out_frame_start = fs_p1;
  assign out_frame       = frame_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: default 640x480 mode, a tiny divided mode
// and a short-line/full-height mode run side by side on one clock.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       fs, ls, vblank, active, hs, vs;
    logic [9:0] x, y;
    logic [7:0] frame;
  } pix_t;

  logic clock;
  logic ra, ea, rb, eb, rc, ec;

  logic       a_vld, a_hs, a_vs, a_active, a_vblank, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic [7:0] a_frame;
  logic       b_vld, b_hs, b_vs, b_active, b_vblank, b_ls, b_fs;
  logic [9:0] b_x, b_y;
  logic [1:0] b_frame;
  logic       c_vld, c_hs, c_vs, c_active, c_vblank, c_ls, c_fs;
  logic [9:0] c_x, c_y;
  logic [7:0] c_frame;

  int n_checks = 0;
  int n_pass   = 0;

  pix_t qa[$], qb[$], qc[$];
  pix_t a_act, b_act, c_act, b_last;

  int ca = 0, ha_run = 0, ha_first = 0, aa_cnt = 0;
  int bcyc = 0, b_lastcyc = 0, b_seen = 0, b_extra = 0, bcnt = 0, bk = 0;
  int bseq[5] = '{0, 1, 2, 3, 0};
  int cc = 0, cvs = 0, cfirst = 0;

  vga_timing_gen u_a (
    .clock(clock), .reset(ra), .in_enable(ea), .out_pix_valid(a_vld),
    .out_vga_hs(a_hs), .out_vga_vs(a_vs), .out_active(a_active), .out_vblank(a_vblank),
    .out_vga_x(a_x), .out_vga_y(a_y), .out_line_start(a_ls), .out_frame_start(a_fs),
    .out_frame(a_frame)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(3), .FRAME_W(2)
  ) u_b (
    .clock(clock), .reset(rb), .in_enable(eb), .out_pix_valid(b_vld),
    .out_vga_hs(b_hs), .out_vga_vs(b_vs), .out_active(b_active), .out_vblank(b_vblank),
    .out_vga_x(b_x), .out_vga_y(b_y), .out_line_start(b_ls), .out_frame_start(b_fs),
    .out_frame(b_frame)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1)
  ) u_c (
    .clock(clock), .reset(rc), .in_enable(ec), .out_pix_valid(c_vld),
    .out_vga_hs(c_hs), .out_vga_vs(c_vs), .out_active(c_active), .out_vblank(c_vblank),
    .out_vga_x(c_x), .out_vga_y(c_y), .out_line_start(c_ls), .out_frame_start(c_fs),
    .out_frame(c_frame)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    else n_pass++;
  endtask

  // Expected outputs for the n-th pixel slot since reset (active-low syncs)
  function automatic pix_t model(int n, int hfp, int hsw, int hbp, int hact,
                                 int vfp, int vsw, int vbp, int vact, int fw);
    int hb, ht, vb, vt, x, y;
    pix_t p;
    hb = hfp + hsw + hbp;
    ht = hb + hact;
    vb = vfp + vsw + vbp;
    vt = vb + vact;
    x  = n % ht;
    y  = (n / ht) % vt;
    p.fs     = (x == 0) && (y == 0);
    p.ls     = (x == 0);
    p.vblank = (y < vb);
    p.active = (x >= hb) && (y >= vb);
    p.hs     = !((x >= hfp) && (x < hfp + hsw));
    p.vs     = !((y >= vfp) && (y < vfp + vsw));
    p.x      = (x >= hb) ? 10'(x - hb) : 10'd0;
    p.y      = (y >= vb) ? 10'(y - vb) : 10'd0;
    p.frame  = 8'(((n + 1) / (ht * vt)) % (1 << fw));
    return p;
  endfunction

  function automatic pix_t pk(logic fs, logic ls, logic vb, logic act, logic hs, logic vs,
                              logic [9:0] x, logic [9:0] y, logic [7:0] fr);
    pix_t p;
    p.fs = fs; p.ls = ls; p.vblank = vb; p.active = act; p.hs = hs; p.vs = vs;
    p.x = x; p.y = y; p.frame = fr;
    return p;
  endfunction

  // Monitor A: default mode
  always @(posedge clock) begin
    #1;
    if (a_vld) begin
      ca++;
      a_act = pk(a_fs, a_ls, a_vblank, a_active, a_hs, a_vs, a_x, a_y, a_frame);
      if (qa.size() == 0) chk("a_extra_valid", 1, 0);
      else chk("a_pixel", a_act, qa.pop_front());
      if (ca <= 800) begin
        if (!a_hs) begin
          ha_run++;
          if (ha_first == 0) ha_first = ca;
        end
        if (a_active) aa_cnt++;
      end
      if (ca == 1) chk("a_first_flags", {a_fs, a_ls, a_vblank, a_active, a_hs, a_vs}, 6'b111011);
      if (ca == 800) begin
        chk("a_hs_low_len", ha_run, 96);
        chk("a_hs_low_start", ha_first, 17);
        chk("a_line0_active", aa_cnt, 0);
      end
      if (ca == 45*800 + 160) chk("a_l45_pre_active", a_active, 0);
      if (ca == 45*800 + 161) chk("a_l45_first", {a_active, a_x, a_y}, {1'b1, 10'd0, 10'd0});
      if (ca == 45*800 + 800) chk("a_l45_last", {a_active, a_x, a_y}, {1'b1, 10'd639, 10'd0});
    end
  end

  // Monitor B: small divided mode
  always @(posedge clock) begin
    #1;
    bcyc++;
    if (b_vld) begin
      b_act = pk(b_fs, b_ls, b_vblank, b_active, b_hs, b_vs, b_x, b_y, {6'd0, b_frame});
      if (qb.size() == 0) chk("b_extra_valid", 1, 0);
      else begin
        b_last = qb.pop_front();
        chk("b_pixel", b_act, b_last);
      end
      if (b_seen != 0) chk("b_valid_gap", bcyc - b_lastcyc, 3 + b_extra);
      b_extra   = 0;
      b_seen    = 1;
      b_lastcyc = bcyc;
      bcnt++;
      if (b_fs) begin
        if (bk > 0) chk("b_frame_period", bcnt, 84);
        if (bk < 5) chk("b_frame_seq", b_frame, bseq[bk]);
        bk++;
        bcnt = 0;
      end
    end else begin
      chk("b_idle_strobes", {b_ls, b_fs}, 2'b00);
    end
  end

  // Monitor C: 12-pixel lines, default vertical timing
  always @(posedge clock) begin
    #1;
    if (c_vld) begin
      cc++;
      c_act = pk(c_fs, c_ls, c_vblank, c_active, c_hs, c_vs, c_x, c_y, c_frame);
      if (qc.size() == 0) chk("c_extra_valid", 1, 0);
      else chk("c_pixel", c_act, qc.pop_front());
      if (cc <= 6300 && !c_vs) begin
        cvs++;
        if (cfirst == 0) cfirst = cc;
      end
      if (cc == 6293) chk("c_last_line_y", {c_active, c_x, c_y}, {1'b1, 10'd0, 10'd479});
      if (cc == 6300) begin
        chk("c_vs_low_count", cvs, 24);
        chk("c_vs_low_start", cfirst, 121);
        chk("c_frame_count", c_frame, 1);
      end
    end
  end

  initial begin
    ra = 1'b1; ea = 1'b0;
    rb = 1'b1; eb = 1'b0;
    rc = 1'b1; ec = 1'b0;
    fork
      begin : branch_a
        repeat (3) @(posedge clock);
        #1;
        chk("a_reset_ctl", {a_vld, a_hs, a_vs, a_active, a_vblank, a_ls, a_fs}, 7'b0110100);
        chk("a_reset_data", {a_x, a_y, a_frame}, 28'd0);
        @(negedge clock);
        for (int n = 0; n < 37100; n++) qa.push_back(model(n, 16, 96, 48, 640, 10, 2, 33, 480, 8));
        ra = 1'b0;
        ea = 1'b1;
        repeat (37100) @(negedge clock);
        ra = 1'b1;
        @(posedge clock);
        #1;
        chk("a_midreset_ctl", {a_vld, a_hs, a_vs, a_active, a_vblank, a_ls, a_fs}, 7'b0110100);
        chk("a_midreset_data", {a_x, a_y, a_frame}, 28'd0);
        chk("a_midreset_drained", qa.size(), 0);
        ca = 0;
        @(negedge clock);
        for (int n = 0; n < 20; n++) qa.push_back(model(n, 16, 96, 48, 640, 10, 2, 33, 480, 8));
        ra = 1'b0;
        repeat (20) @(negedge clock);
        ea = 1'b0;
        repeat (2) @(negedge clock);
        chk("a_queue_empty", qa.size(), 0);
      end
      begin : branch_b
        repeat (3) @(posedge clock);
        #1;
        chk("b_reset_ctl", {b_vld, b_hs, b_vs, b_active, b_vblank, b_ls, b_fs}, 7'b0110100);
        @(negedge clock);
        for (int n = 0; n < 356; n++) qb.push_back(model(n, 1, 2, 1, 8, 1, 1, 1, 4, 2));
        rb = 1'b0;
        eb = 1'b1;
        repeat (301) @(negedge clock);
        eb = 1'b0;
        b_extra = 10;
        repeat (10) begin
          @(posedge clock);
          #1;
          chk("b_freeze_strobes", {b_vld, b_ls, b_fs}, 3'b000);
          chk("b_freeze_levels", {b_hs, b_vs, b_active, b_vblank, b_x, b_y, b_frame},
              {b_last.hs, b_last.vs, b_last.active, b_last.vblank, b_last.x, b_last.y,
               b_last.frame[1:0]});
        end
        @(negedge clock);
        eb = 1'b1;
        for (int i = 0; i < 2000 && qb.size() != 0; i++) @(negedge clock);
        eb = 1'b0;
        repeat (4) @(negedge clock);
        chk("b_queue_empty", qb.size(), 0);
        chk("b_frame_starts_seen", bk, 5);
      end
      begin : branch_c
        repeat (3) @(negedge clock);
        for (int n = 0; n < 6312; n++) qc.push_back(model(n, 1, 2, 1, 8, 10, 2, 33, 480, 8));
        rc = 1'b0;
        ec = 1'b1;
        repeat (6312) @(negedge clock);
        ec = 1'b0;
        repeat (2) @(negedge clock);
        chk("c_queue_empty", qc.size(), 0);
      end
    join
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
